// File: rtl/tdm_demux_16_if.sv
// tdm_demux_16_if
// Bus bundle for the 16-channel TDM demultiplexer.
//   din, din_valid, frame_start : incoming serial/TDM beat
//   sel_mode, sel               : auto-scan vs direct-addressed write target
//   dout                        : 16 channel words, channel 0 leftmost
//   ch_idx, frame_done,
//   sync_err, busy              : scan position and status pulses
// slave is the demux view, master is the driver view.
interface tdm_demux_16_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]      din;
    logic                  din_valid;
    logic                  frame_start;
    logic                  sel_mode;
    logic [3:0]            sel;
    logic [0:16*WIDTH-1]   dout;
    logic [3:0]            ch_idx;
    logic                  frame_done;
    logic                  sync_err;
    logic                  busy;

    modport master (
        output din, din_valid, frame_start, sel_mode, sel,
        input  dout, ch_idx, frame_done, sync_err, busy
    );

    modport slave (
        input  din, din_valid, frame_start, sel_mode, sel,
        output dout, ch_idx, frame_done, sync_err, busy
    );
endinterface

// File: rtl/tdm_demux_16.sv
// tdm_demux_16
// Scatters a TDM stream (one channel word per valid beat, channel 0 first)
// into 16 registered channel outputs. In auto mode words collect in a shadow
// buffer and all 16 outputs update together when channel 15 arrives. In
// direct mode each valid beat writes the channel picked by sel.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : tdm_demux_16_if.slave (stream in, channel words and status out)
//
// state | meaning
// IDLE  | waiting for a frame_start beat (auto) or parked (direct mode)
// SCAN  | collecting channels 1..15 of the current frame
module tdm_demux_16 #(
    parameter int WIDTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux_16_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          ch_idx_q, ch_idx_nxt;
    logic [WIDTH-1:0]    shadow [16];
    logic [WIDTH-1:0]    ch_q   [16];
    logic                frame_done_q, frame_done_nxt;
    logic                sync_err_q, sync_err_nxt;
    logic                shadow_we;
    logic [3:0]          shadow_addr;
    logic                frame_load;
    logic                direct_we;
    logic [0:16*WIDTH-1] dout_pk;

    always_comb begin
        state_nxt      = state;
        ch_idx_nxt     = ch_idx_q;
        shadow_we      = 1'b0;
        shadow_addr    = ch_idx_q;
        frame_load     = 1'b0;
        direct_we      = 1'b0;
        frame_done_nxt = 1'b0;
        sync_err_nxt   = 1'b0;
        if (bus.sel_mode) begin
            // Direct mode drops any partial frame without flagging it.
            state_nxt  = IDLE;
            ch_idx_nxt = 4'd0;
            direct_we  = bus.din_valid;
        end else if (bus.din_valid) begin
            case (state)
                IDLE: begin
                    if (bus.frame_start) begin
                        shadow_we   = 1'b1;
                        shadow_addr = 4'd0;
                        ch_idx_nxt  = 4'd1;
                        state_nxt   = SCAN;
                    end
                end
                SCAN: begin
                    // frame_start wins over completion: a start beat in
                    // place of channel 15 is a resync, not a finished frame.
                    if (bus.frame_start) begin
                        sync_err_nxt = (ch_idx_q != 4'd0);
                        shadow_we    = 1'b1;
                        shadow_addr  = 4'd0;
                        ch_idx_nxt   = 4'd1;
                    end else if (ch_idx_q == 4'd15) begin
                        frame_load     = 1'b1;
                        frame_done_nxt = 1'b1;
                        ch_idx_nxt     = 4'd0;
                        state_nxt      = IDLE;
                    end else begin
                        shadow_we  = 1'b1;
                        ch_idx_nxt = ch_idx_q + 4'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ch_idx_q     <= 4'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                shadow[k] <= '0;
                ch_q[k]   <= '0;
            end
        end else begin
            state        <= state_nxt;
            ch_idx_q     <= ch_idx_nxt;
            frame_done_q <= frame_done_nxt;
            sync_err_q   <= sync_err_nxt;
            if (shadow_we) begin
                shadow[shadow_addr] <= bus.din;
            end
            // Channel 15 goes straight from din so the whole frame lands
            // in one edge.
            if (frame_load) begin
                for (int k = 0; k < 15; k++) begin
                    ch_q[k] <= shadow[k];
                end
                ch_q[15] <= bus.din;
            end else if (direct_we) begin
                ch_q[bus.sel] <= bus.din;
            end
        end
    end

    always_comb begin
        dout_pk = '0;
        for (int k = 0; k < 16; k++) begin
            dout_pk[k*WIDTH +: WIDTH] = ch_q[k];
        end
    end

    assign bus.dout       = dout_pk;
    assign bus.ch_idx     = ch_idx_q;
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.busy       = (state == SCAN);
endmodule
